// File: rtl/hazard_ctrl_stage_if.sv
// ID/EX control-stage bus: decoded control bundles in, registered bundles out.
// HAZARD_STATS_EN adds the Bubble_Total_Out statistics output.
interface hazard_ctrl_stage_if #(
  parameter int WB_W  = 2,
  parameter int MEM_W = 2,
  parameter int EX_W  = 4,
  parameter int CNT_W = 2
);
  logic [WB_W-1:0]  WriteBack_In;
  logic [MEM_W-1:0] Memory_In;
  logic [EX_W-1:0]  Execution_In;
  logic             Valid_In;
  logic             Hazard_In;
  logic [CNT_W-1:0] Bubble_Len_In;
  logic             Stall_In;
  logic             Flush_In;
  logic [WB_W-1:0]  WriteBack_Out;
  logic [MEM_W-1:0] Memory_Out;
  logic [EX_W-1:0]  Execution_Out;
  logic             Valid_Out;
  logic             Bubble_Active_Out;
  logic             Hold_Out;
`ifdef HAZARD_STATS_EN
  logic [15:0]      Bubble_Total_Out;

  modport master (
    output WriteBack_In, Memory_In, Execution_In, Valid_In,
           Hazard_In, Bubble_Len_In, Stall_In, Flush_In,
    input  WriteBack_Out, Memory_Out, Execution_Out, Valid_Out,
           Bubble_Active_Out, Hold_Out, Bubble_Total_Out
  );
  modport slave (
    input  WriteBack_In, Memory_In, Execution_In, Valid_In,
           Hazard_In, Bubble_Len_In, Stall_In, Flush_In,
    output WriteBack_Out, Memory_Out, Execution_Out, Valid_Out,
           Bubble_Active_Out, Hold_Out, Bubble_Total_Out
  );
`else
  modport master (
    output WriteBack_In, Memory_In, Execution_In, Valid_In,
           Hazard_In, Bubble_Len_In, Stall_In, Flush_In,
    input  WriteBack_Out, Memory_Out, Execution_Out, Valid_Out,
           Bubble_Active_Out, Hold_Out
  );
  modport slave (
    input  WriteBack_In, Memory_In, Execution_In, Valid_In,
           Hazard_In, Bubble_Len_In, Stall_In, Flush_In,
    output WriteBack_Out, Memory_Out, Execution_Out, Valid_Out,
           Bubble_Active_Out, Hold_Out
  );
`endif
endinterface

// File: rtl/hazard_ctrl_stage.sv
// Registered ID/EX hazard control stage: inserts 1..MAX_BUBBLES bubbles per hazard,
// with stall/flush. Optional macro HAZARD_STATS_EN adds a saturating bubble counter.
module hazard_ctrl_stage #(
  parameter int WB_W        = 2,
  parameter int MEM_W       = 2,
  parameter int EX_W        = 4,
  parameter int MAX_BUBBLES = 3,
  parameter int CNT_W       = $clog2(MAX_BUBBLES+1)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  hazard_ctrl_stage_if.slave   bus
);

  typedef enum logic {IDLE, BUBBLE} state_t;

  typedef struct packed {
    logic [WB_W-1:0]  wb;
    logic [MEM_W-1:0] mem;
    logic [EX_W-1:0]  ex;
    logic             vld;
    logic             bub;
  } ctl_t;

  localparam logic [CNT_W-1:0] ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0] MAX_L = CNT_W'(MAX_BUBBLES);
  localparam ctl_t BUB_CTL = '{wb: '0, mem: '0, ex: '0, vld: 1'b0, bub: 1'b1};

  state_t           state_q, state_d;
  logic [CNT_W-1:0] rem_q, rem_d, eff_len;
  ctl_t             ctl_q, ctl_d, ctl_in;
  logic             bub_cap;

  assign ctl_in = '{wb: bus.WriteBack_In, mem: bus.Memory_In, ex: bus.Execution_In,
                    vld: bus.Valid_In, bub: 1'b0};

  // zero-length requests still cost one bubble; oversize requests clamp
  always_comb begin
    eff_len = bus.Bubble_Len_In;
    if (bus.Bubble_Len_In == '0)
      eff_len = ONE;
    else if (bus.Bubble_Len_In > MAX_L)
      eff_len = MAX_L;
  end

  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    ctl_d   = ctl_q;
    if (bus.Flush_In) begin
      state_d = IDLE;
      rem_d   = '0;
      ctl_d   = '0;
    end else if (!bus.Stall_In) begin
      case (state_q)
        IDLE: begin
          if (bus.Hazard_In) begin
            ctl_d   = BUB_CTL;
            rem_d   = eff_len - ONE;
            state_d = (eff_len > ONE) ? BUBBLE : IDLE;
          end else begin
            ctl_d = ctl_in;
          end
        end
        BUBBLE: begin
          // hazard requests are ignored mid-run: no extension, no restart
          ctl_d = BUB_CTL;
          rem_d = rem_q - ONE;
          if (rem_q == ONE)
            state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      rem_q   <= '0;
      ctl_q   <= '0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      ctl_q   <= ctl_d;
    end
  end

  assign bus.Hold_Out = !bus.Flush_In &
                        ((state_q == BUBBLE) | ((state_q == IDLE) & bus.Hazard_In) | bus.Stall_In);

  assign bus.WriteBack_Out     = ctl_q.wb;
  assign bus.Memory_Out        = ctl_q.mem;
  assign bus.Execution_Out     = ctl_q.ex;
  assign bus.Valid_Out         = ctl_q.vld;
  assign bus.Bubble_Active_Out = ctl_q.bub;

  // an edge captures a bubble when it is neither flushed nor stalled and a run is live or starting
  assign bub_cap = !bus.Flush_In & !bus.Stall_In & ((state_q == BUBBLE) | bus.Hazard_In);

`ifdef HAZARD_STATS_EN
  logic [15:0] total_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      total_q <= '0;
    else if (bub_cap && total_q != 16'hFFFF)
      total_q <= total_q + 16'd1;
  end

  assign bus.Bubble_Total_Out = total_q;
`else
  logic unused_cap;
  assign unused_cap = bub_cap;
`endif

endmodule

// File: tb/tb_hazard_ctrl_stage.sv
// Scoreboard bench for hazard_ctrl_stage: directed vectors push expectations, a monitor pops/compares.
module tb_hazard_ctrl_stage;

  typedef struct {
    logic [1:0]  wb;
    logic [1:0]  mem;
    logic [3:0]  ex;
    logic        vld;
    logic        bub;
    logic        hold;
    logic        chk2;
    logic        bub2;
    logic [15:0] total;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic rst2_n = 1'b0;
  always #5 clk = ~clk;

  hazard_ctrl_stage_if #(.WB_W(2), .MEM_W(2), .EX_W(4), .CNT_W(2)) b1 ();
  hazard_ctrl_stage_if #(.WB_W(2), .MEM_W(2), .EX_W(4), .CNT_W(2)) b2 ();

  hazard_ctrl_stage #(.WB_W(2), .MEM_W(2), .EX_W(4), .MAX_BUBBLES(3)) dut (
    .clk(clk), .rst_n(rst_n), .bus(b1.slave));

  // second instance with a shorter maximum run, fed the same inputs, for the clamp case
  hazard_ctrl_stage #(.WB_W(2), .MEM_W(2), .EX_W(4), .MAX_BUBBLES(2)) dut2 (
    .clk(clk), .rst_n(rst2_n), .bus(b2.slave));

  assign b2.WriteBack_In  = b1.WriteBack_In;
  assign b2.Memory_In     = b1.Memory_In;
  assign b2.Execution_In  = b1.Execution_In;
  assign b2.Valid_In      = b1.Valid_In;
  assign b2.Hazard_In     = b1.Hazard_In;
  assign b2.Bubble_Len_In = b1.Bubble_Len_In;
  assign b2.Stall_In      = b1.Stall_In;
  assign b2.Flush_In      = b1.Flush_In;

  exp_t q[$];
  int   vecs = 0;
  int   miscmp = 0;
  logic [15:0] exp_total = '0;

  task automatic apply(input logic [1:0] wb, input logic [1:0] mem, input logic [3:0] ex,
                       input logic vin, input logic haz, input logic [1:0] len,
                       input logic stall, input logic flush,
                       input logic [1:0] ewb, input logic [1:0] emem, input logic [3:0] eex,
                       input logic evld, input logic ebub, input logic ehold,
                       input logic chk2 = 1'b0, input logic ebub2 = 1'b0);
    exp_t e;
    @(negedge clk);
    b1.WriteBack_In  = wb;
    b1.Memory_In     = mem;
    b1.Execution_In  = ex;
    b1.Valid_In      = vin;
    b1.Hazard_In     = haz;
    b1.Bubble_Len_In = len;
    b1.Stall_In      = stall;
    b1.Flush_In      = flush;
    if (ebub && !stall && !flush && exp_total != 16'hFFFF)
      exp_total = exp_total + 16'd1;
    e.wb = ewb; e.mem = emem; e.ex = eex; e.vld = evld; e.bub = ebub; e.hold = ehold;
    e.chk2 = chk2; e.bub2 = ebub2; e.total = exp_total;
    q.push_back(e);
  endtask

  // Hold_Out is sampled mid-low-phase with the vector applied; registered outputs after the edge
  initial begin
    exp_t e;
    logic h, bad;
    forever begin
      @(negedge clk);
      #2;
      if (q.size() > 0) begin
        h = b1.Hold_Out;
        @(posedge clk);
        #1;
        e = q.pop_front();
        bad = (b1.WriteBack_Out !== e.wb) || (b1.Memory_Out !== e.mem) ||
              (b1.Execution_Out !== e.ex) || (b1.Valid_Out !== e.vld) ||
              (b1.Bubble_Active_Out !== e.bub) || (h !== e.hold) ||
              (e.chk2 && (b2.Bubble_Active_Out !== e.bub2));
`ifdef HAZARD_STATS_EN
        if (b1.Bubble_Total_Out !== e.total) bad = 1'b1;
`endif
        vecs++;
        if (bad) begin
          miscmp++;
          $display("FAIL vec%0d got wb=%b mem=%b ex=%b v=%b bub=%b hold=%b bub2=%b want wb=%b mem=%b ex=%b v=%b bub=%b hold=%b bub2=%b(chk %b)",
                   vecs, b1.WriteBack_Out, b1.Memory_Out, b1.Execution_Out, b1.Valid_Out,
                   b1.Bubble_Active_Out, h, b2.Bubble_Active_Out,
                   e.wb, e.mem, e.ex, e.vld, e.bub, e.hold, e.bub2, e.chk2);
`ifdef HAZARD_STATS_EN
          $display("FAIL vec%0d total got %0d want %0d", vecs, b1.Bubble_Total_Out, e.total);
`endif
        end
      end
    end
  end

  task automatic check_reset(input string name);
    vecs++;
    if ({b1.WriteBack_Out, b1.Memory_Out, b1.Execution_Out, b1.Valid_Out,
         b1.Bubble_Active_Out, b1.Hold_Out} !== 11'b0) begin
      miscmp++;
      $display("FAIL %s got wb=%b mem=%b ex=%b v=%b bub=%b hold=%b want all 0", name,
               b1.WriteBack_Out, b1.Memory_Out, b1.Execution_Out, b1.Valid_Out,
               b1.Bubble_Active_Out, b1.Hold_Out);
    end
`ifdef HAZARD_STATS_EN
    vecs++;
    if (b1.Bubble_Total_Out !== 16'd0) begin
      miscmp++;
      $display("FAIL %s total got %0d want 0", name, b1.Bubble_Total_Out);
    end
`endif
  endtask

  initial begin
    b1.WriteBack_In = '0; b1.Memory_In = '0; b1.Execution_In = '0; b1.Valid_In = 1'b0;
    b1.Hazard_In = 1'b0; b1.Bubble_Len_In = '0; b1.Stall_In = 1'b0; b1.Flush_In = 1'b0;
    #12;
    check_reset("reset_state");
    @(negedge clk);
    rst_n = 1'b1;

    // plain pass-through
    apply(2'b01, 2'b10, 4'b1010, 1, 0, 2'd0, 0, 0,  2'b01, 2'b10, 4'b1010, 1, 0, 0);
    // hazard L=2: two bubbles with Hold, then pass
    apply(2'b01, 2'b10, 4'b1010, 1, 1, 2'd2, 0, 0,  2'b00, 2'b00, 4'b0000, 0, 1, 1);
    apply(2'b01, 2'b10, 4'b1010, 1, 0, 2'd0, 0, 0,  2'b00, 2'b00, 4'b0000, 0, 1, 1);
    apply(2'b01, 2'b10, 4'b1010, 1, 0, 2'd0, 0, 0,  2'b01, 2'b10, 4'b1010, 1, 0, 0);
    // zero length behaves as one bubble
    apply(2'b11, 2'b01, 4'b0101, 1, 1, 2'd0, 0, 0,  2'b00, 2'b00, 4'b0000, 0, 1, 1);
    apply(2'b11, 2'b01, 4'b0101, 1, 0, 2'd0, 0, 0,  2'b11, 2'b01, 4'b0101, 1, 0, 0);
    // L=3 with Hazard_In held high: run is not extended
    apply(2'b00, 2'b11, 4'b0110, 1, 1, 2'd3, 0, 0,  2'b00, 2'b00, 4'b0000, 0, 1, 1);
    apply(2'b00, 2'b11, 4'b0110, 1, 1, 2'd3, 0, 0,  2'b00, 2'b00, 4'b0000, 0, 1, 1);
    apply(2'b00, 2'b11, 4'b0110, 1, 1, 2'd3, 0, 0,  2'b00, 2'b00, 4'b0000, 0, 1, 1);
    apply(2'b00, 2'b11, 4'b0110, 1, 0, 2'd0, 0, 0,  2'b00, 2'b11, 4'b0110, 1, 0, 0);
    // stall two cycles after the first bubble of an L=3 run
    apply(2'b10, 2'b10, 4'b1100, 1, 1, 2'd3, 0, 0,  2'b00, 2'b00, 4'b0000, 0, 1, 1);
    apply(2'b10, 2'b10, 4'b1100, 1, 0, 2'd0, 1, 0,  2'b00, 2'b00, 4'b0000, 0, 1, 1);
    apply(2'b10, 2'b10, 4'b1100, 1, 0, 2'd0, 1, 0,  2'b00, 2'b00, 4'b0000, 0, 1, 1);
    apply(2'b10, 2'b10, 4'b1100, 1, 0, 2'd0, 0, 0,  2'b00, 2'b00, 4'b0000, 0, 1, 1);
    apply(2'b10, 2'b10, 4'b1100, 1, 0, 2'd0, 0, 0,  2'b00, 2'b00, 4'b0000, 0, 1, 1);
    apply(2'b10, 2'b10, 4'b1100, 1, 0, 2'd0, 0, 0,  2'b10, 2'b10, 4'b1100, 1, 0, 0);
    // stall while idle holds the previous capture; then a Valid_In=0 pass
    apply(2'b01, 2'b01, 4'b0001, 0, 0, 2'd0, 1, 0,  2'b10, 2'b10, 4'b1100, 1, 0, 1);
    apply(2'b01, 2'b01, 4'b0001, 0, 0, 2'd0, 0, 0,  2'b01, 2'b01, 4'b0001, 0, 0, 0);
    // flush on the second bubble of an L=3 run
    apply(2'b11, 2'b11, 4'b1111, 1, 1, 2'd3, 0, 0,  2'b00, 2'b00, 4'b0000, 0, 1, 1);
    apply(2'b11, 2'b11, 4'b1111, 1, 0, 2'd0, 0, 1,  2'b00, 2'b00, 4'b0000, 0, 0, 0);
    apply(2'b01, 2'b10, 4'b1010, 1, 0, 2'd0, 0, 0,  2'b01, 2'b10, 4'b1010, 1, 0, 0);
    // flush + stall + hazard together in IDLE: flush wins, no run
    apply(2'b11, 2'b11, 4'b1111, 1, 1, 2'd2, 1, 1,  2'b00, 2'b00, 4'b0000, 0, 0, 0);
    apply(2'b10, 2'b01, 4'b0110, 0, 0, 2'd0, 0, 0,  2'b10, 2'b01, 4'b0110, 0, 0, 0);
    // length 3 against MAX_BUBBLES=2 on dut2: two bubbles there, three on dut
    rst2_n = 1'b1;
    apply(2'b01, 2'b10, 4'b1010, 1, 1, 2'd3, 0, 0,  2'b00, 2'b00, 4'b0000, 0, 1, 1, 1, 1);
    apply(2'b01, 2'b10, 4'b1010, 1, 0, 2'd0, 0, 0,  2'b00, 2'b00, 4'b0000, 0, 1, 1, 1, 1);
    apply(2'b01, 2'b10, 4'b1010, 1, 0, 2'd0, 0, 0,  2'b00, 2'b00, 4'b0000, 0, 1, 1, 1, 0);
    apply(2'b01, 2'b10, 4'b1010, 1, 0, 2'd0, 0, 0,  2'b01, 2'b10, 4'b1010, 1, 0, 0, 1, 0);
    // asynchronous reset in the middle of an L=3 run
    apply(2'b11, 2'b00, 4'b0011, 1, 1, 2'd3, 0, 0,  2'b00, 2'b00, 4'b0000, 0, 1, 1);
    @(posedge clk);
    #2;
    b1.Hazard_In = 1'b0;
    #1;
    rst_n = 1'b0;
    exp_total = '0;
    #1;
    check_reset("async_reset_midrun");
    @(negedge clk);
    rst_n = 1'b1;
    apply(2'b01, 2'b10, 4'b1010, 1, 0, 2'd0, 0, 0,  2'b01, 2'b10, 4'b1010, 1, 0, 0);
    apply(2'b10, 2'b01, 4'b0101, 1, 0, 2'd0, 0, 0,  2'b10, 2'b01, 4'b0101, 1, 0, 0);

    for (int i = 0; i < 50 && q.size() > 0; i++) @(posedge clk);
    #3;
    if (q.size() > 0) begin
      miscmp++;
      $display("FAIL drain got %0d pending want 0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vecs, miscmp);
    $finish;
  end

endmodule

// File: doc/hazard_ctrl_stage.md
Name: hazard_ctrl_stage

Overview:
- Parametrised, registered successor to the combinational hazard control mux.
- Sits at the ID/EX boundary. Captures the WB/MEM/EX control bundles each cycle.
- On a hazard request it inserts a programmable run of 1..MAX_BUBBLES all-zero bubbles and holds upstream until the run ends.
- Also supports pipeline stall (hold) and flush (zero), and drives a valid bit.

Parameters:
- WB_W, 2, width of write-back control bundle
- MEM_W, 2, width of memory control bundle
- EX_W, 4, width of execution control bundle
- MAX_BUBBLES, 3, longest bubble run per hazard request (>=1)
- CNT_W, $clog2(MAX_BUBBLES+1), width of bubble-length and remaining-count fields

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  reset; one clock, reset asynchronous active-low
- WriteBack_In  in  WB_W  decoded WB controls
- Memory_In  in  MEM_W  decoded MEM controls
- Execution_In  in  EX_W  decoded EX controls
- Valid_In  in  1  incoming instruction valid
- Hazard_In  in  1  bubble-run request
- Bubble_Len_In  in  CNT_W  requested bubble count, sampled with Hazard_In
- Stall_In  in  1  freeze stage: hold outputs and counter
- Flush_In  in  1  kill stage contents and any bubble run
- WriteBack_Out  out  WB_W  registered WB controls
- Memory_Out  out  MEM_W  registered MEM controls
- Execution_Out  out  EX_W  registered EX controls
- Valid_Out  out  1  registered valid; 0 for bubbles
- Bubble_Active_Out  out  1  current output is an inserted bubble
- Hold_Out  out  1  combinational; upstream PC/IF-ID must not advance

Behaviour:
- Reset (rst_n=0, asynchronous):
  - All bundle outputs 0, Valid_Out=0, Bubble_Active_Out=0.
  - State=IDLE, remaining count=0.
- Latency: 1 cycle. Inputs sampled at posedge appear on outputs after that edge.
- States:
  - IDLE: normal pass-through.
  - BUBBLE: remaining count > 0.
- Per-edge priority (highest first): Flush_In, Stall_In, state action.
- Flush_In=1:
  - Outputs zeroed, Valid_Out=0, Bubble_Active_Out=0.
  - remaining=0, state=IDLE. Applies in either state, including mid-run.
- Stall_In=1 (no flush):
  - All registers unchanged, including state, remaining count and Bubble_Active_Out.
  - A Hazard_In asserted in the same cycle is dropped; the requester must hold it.
- IDLE, Hazard_In=1:
  - Effective length L = Bubble_Len_In, with 0 treated as 1 and values above MAX_BUBBLES clamped to MAX_BUBBLES.
  - Capture zero bundles, Valid_Out=0, Bubble_Active_Out=1.
  - remaining=L-1. Go to BUBBLE if L>1, else stay IDLE.
- IDLE, Hazard_In=0: capture the input bundles and Valid_In; Bubble_Active_Out=0.
- BUBBLE:
  - Capture zero bundles, Valid_Out=0, Bubble_Active_Out=1.
  - remaining decrements; go to IDLE on the edge where remaining goes 1→0.
  - Hazard_In is ignored: no extension, no restart.
- Hold_Out = (state==BUBBLE) | (state==IDLE & Hazard_In) | Stall_In.
  - Hold_Out is forced to 0 when Flush_In=1.
- Exactly L consecutive bubble cycles per accepted request, absent stall/flush. Stall cycles stretch the run without consuming count.
- Input bundles presented while Hold_Out=1 are not captured; upstream re-presents them.

Optional Feature:
- Macro: HAZARD_STATS_EN.
- Defined:
  - Adds output Bubble_Total_Out (16 bits).
  - Increments by 1 on every edge that captures a bubble; stall cycles do not count.
  - Saturates at 16'hFFFF. Cleared by reset only; flush does not clear it.
- Undefined: port and counter absent. All other behaviour identical.

Test Plan:
- Reset mid-run: L=3 accepted, rst_n dropped asynchronously between edges -> all outputs 0 immediately, state IDLE; after release, WB=2'b01 MEM=2'b10 EX=4'b1010 Valid_In=1 passes -> outputs equal inputs one cycle later.
- Hazard L=2: WB=01 MEM=10 EX=1010 with Hazard_In=1, Bubble_Len_In=2 for one cycle -> two cycles of all-zero bundles, Valid_Out=0, Bubble_Active_Out=1; Hold_Out=1 for those two cycles; third cycle passes inputs.
- Clamp/zero length: Bubble_Len_In=0 -> exactly 1 bubble; Bubble_Len_In=3 with MAX_BUBBLES=2 -> exactly 2 bubbles.
- Stall inside run: L=3, Stall_In=1 for 2 cycles after first bubble -> outputs frozen as bubble, 3 bubble captures total over 5 cycles; with HAZARD_STATS_EN, Bubble_Total_Out=3.
- Flush inside run: L=3, Flush_In=1 on second bubble cycle -> next outputs zero, Bubble_Active_Out=0, Hold_Out=0; following cycle passes EX=4'b1010 normally.
- Flush+Stall+Hazard same cycle, IDLE -> flush wins: zeroed, Valid_Out=0, no bubble run started.
